cmc_operand_queue: RTL

Parametrised operand queue for the queue-calculator datapath. It holds up to DEPTH operands of DATA_W bits in a circular buffer. It accepts push, reduce, pop and clear commands over a valid/ready handshake. It always presents the two front operands to the external ALU, and reports precise error causes. It replaces the fixed 5×8 shifting queue, adding pointer-based storage, a clear command, occupancy/full outputs, coded sticky errors and optional halt-on-error back-pressure.

---
 rtl/cmc_pkg.sv | 22 ++
 rtl/cmc_ring_ptr.sv | 31 +++
 rtl/cmc_operand_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cmc_pkg.sv
// Shared types and constants for the queue-calculator operand queue.
// Opcode and error-code encodings are fixed by the command interface.
package cmc_pkg;

    typedef enum logic [1:0] {
        OP_PUSH   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_REDUCE = 2'b10,
        OP_POP    = 2'b11
    } cmc_op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDER_RED = 2'd2,
        ERR_UNDER_POP = 2'd3
    } cmc_err_e;

    // Fill bit replicated across the operand width to form the default PAD.
    localparam logic CMC_PAD_FILL = 1'b1;

endpackage

// File: rtl/cmc_ring_ptr.sv
// Modulo-DEPTH pointer register with +1 / +2 advance and synchronous zero.
// Wrap is free because DEPTH is a power of two.
module cmc_ring_ptr #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc1,
    input  logic          i_inc2,
    output logic [AW-1:0] o_ptr
);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc2) begin
            r_ptr <= r_ptr + AW'(2);
        end else if (i_inc1) begin
            r_ptr <= r_ptr + AW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/cmc_operand_queue.sv
// Circular operand queue: PUSH/REDUCE/POP/CLEAR with exact occupancy,
// combinational front/tail reads and sticky first-cause error reporting.
module cmc_operand_queue
    import cmc_pkg::*;
#(
    parameter  int               DATA_W      = 8,
    parameter  int               DEPTH       = 8,
    parameter  logic [DATA_W-1:0] PAD        = {DATA_W{CMC_PAD_FILL}},
    parameter  bit               HALT_ON_ERR = 1'b0,
    localparam int               AW          = $clog2(DEPTH),
    localparam int               CW          = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] front0,
    output logic [DATA_W-1:0] front1,
    output logic [DATA_W-1:0] tail,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CW-1:0]     r_count;
    logic              r_err;
    cmc_err_e          r_code;

    logic [AW-1:0] w_rd_ptr;
    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_rd_nxt;
    logic [AW-1:0] w_tail_ptr;
    logic          w_fire;
    logic          w_push;
    logic          w_clear;
    logic          w_reduce;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_lt2;
    logic          w_push_ok;
    logic          w_red_ok;
    logic          w_pop_ok;
    logic          w_write;
    cmc_err_e      w_err_code;

    assign w_fire  = cmd_valid && cmd_ready;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_lt2   = (r_count < CW'(2));

    always_comb begin
        w_push   = 1'b0;
        w_clear  = 1'b0;
        w_reduce = 1'b0;
        w_pop    = 1'b0;
        if (w_fire) begin
            unique case (cmc_op_e'(cmd_op))
                OP_PUSH:   w_push   = 1'b1;
                OP_CLEAR:  w_clear  = 1'b1;
                OP_REDUCE: w_reduce = 1'b1;
                OP_POP:    w_pop    = 1'b1;
            endcase
        end
    end

    // An erroring command is consumed but leaves the queue untouched.
    always_comb begin
        w_err_code = ERR_NONE;
        if (w_push && w_full) begin
            w_err_code = ERR_OVERFLOW;
        end else if (w_reduce && w_lt2) begin
            w_err_code = ERR_UNDER_RED;
        end else if (w_pop && w_empty) begin
            w_err_code = ERR_UNDER_POP;
        end
    end

    assign w_push_ok = w_push && !w_full;
    assign w_red_ok  = w_reduce && !w_lt2;
    assign w_pop_ok  = w_pop && !w_empty;
    assign w_write   = w_push_ok || w_red_ok;

    cmc_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clear),
        .i_inc1 (w_pop_ok),
        .i_inc2 (w_red_ok),
        .o_ptr  (w_rd_ptr)
    );

    cmc_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clear),
        .i_inc1 (w_write),
        .i_inc2 (1'b0),
        .o_ptr  (w_wr_ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[w_wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_clear) begin
            r_count <= '0;
        end else if (w_push_ok) begin
            r_count <= r_count + CW'(1);
        end else if (w_red_ok || w_pop_ok) begin
            r_count <= r_count - CW'(1);
        end
    end

    // First cause is held; a new error in the err_clr cycle reloads the code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_code <= ERR_NONE;
        end else if (w_err_code != ERR_NONE) begin
            r_err <= 1'b1;
            if (!r_err || err_clr) begin
                r_code <= w_err_code;
            end
        end else if (err_clr) begin
            r_err  <= 1'b0;
            r_code <= ERR_NONE;
        end
    end

    assign w_rd_nxt   = w_rd_ptr + AW'(1);
    assign w_tail_ptr = w_wr_ptr - AW'(1);

    assign front0    = w_empty ? '0 : r_mem[w_rd_ptr];
    assign front1    = w_lt2 ? PAD : r_mem[w_rd_nxt];
    assign tail      = w_empty ? '0 : r_mem[w_tail_ptr];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign err       = r_err;
    assign err_code  = r_code;
    assign cmd_ready = !(HALT_ON_ERR && r_err);

endmodule
